spi_master_reader: RTL and testbench

- SPI master that initiates one 16-bit full-duplex frame per start request.
- Drives SCK, CS and MOSI toward the FPGA slave interface and shifts in the slave's MISO reply.
- Sits on the master side of the board link. It exists to exercise and read back the slave's 16-bit MISO response path.
- CS is active-high across this link.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_div.sv | 28 ++
 rtl/spi_master_reader.sv | 129 ++++++++++++
 tb/tb_spi_master_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master reader.
// Frame width, word type and FSM state encoding.
package spi_pkg;

    localparam int FRAME_W = 16;

    typedef logic [FRAME_W-1:0] spi_word_t;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period timebase.
// Counts while the FSM is active and ticks every CLK_DIV cycles.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic SLK,
    input  logic rst,
    input  logic load,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = !load && (cnt == 8'(CLK_DIV - 1));

    // Every state change happens on a tick, so clearing on tick
    // restarts the count for the next state.
    always_ff @(posedge SLK or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_reader.sv
// SPI master: one 16-bit full-duplex frame per start request.
// CS active-high, SCK idles low, MISO sampled on SCK falling edge.
module spi_master_reader #(
    parameter int FRAME_W = 16,
    parameter int CLK_DIV = 2
) (
    input  logic               SLK,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] tx_data,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] rx_data,
    output logic               SCK,
    output logic               CS,
    output logic               MOSI,
    input  logic               MISO
);

    import spi_pkg::*;

    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

    state_t    state, state_n;
    spi_word_t tx_sr, tx_n;
    spi_word_t rx_sr, rsr_n;
    spi_word_t rx_n;
    logic [3:0] bitcnt, bit_n;
    logic sck_n, cs_n, mosi_n, busy_n, done_n;
    logic tick;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .SLK (SLK),
        .rst (rst),
        .load(state == IDLE),
        .tick(tick)
    );

    always_ff @(posedge SLK or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            bitcnt  <= '0;
            SCK     <= 1'b0;
            CS      <= 1'b0;
            MOSI    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            tx_sr   <= tx_n;
            rx_sr   <= rsr_n;
            rx_data <= rx_n;
            bitcnt  <= bit_n;
            SCK     <= sck_n;
            CS      <= cs_n;
            MOSI    <= mosi_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        tx_n    = tx_sr;
        rsr_n   = rx_sr;
        rx_n    = rx_data;
        bit_n   = bitcnt;
        sck_n   = SCK;
        cs_n    = CS;
        mosi_n  = MOSI;
        busy_n  = busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    tx_n    = tx_data;
                    cs_n    = 1'b1;
                    busy_n  = 1'b1;
                    mosi_n  = tx_data[FRAME_W-1];
                    bit_n   = '0;
                    state_n = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    sck_n   = 1'b1;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    rsr_n = {rx_sr[FRAME_W-2:0], MISO};
                    sck_n = 1'b0;
                    if (bitcnt == LAST_BIT) begin
                        state_n = TRAIL;
                    end else begin
                        bit_n   = bitcnt + 4'd1;
                        mosi_n  = tx_sr[FRAME_W-2];
                        tx_n    = {tx_sr[FRAME_W-2:0], 1'b0};
                        state_n = LOW;
                    end
                end
            end
            LOW: begin
                if (tick) begin
                    sck_n   = 1'b1;
                    state_n = HIGH;
                end
            end
            TRAIL: begin
                if (tick) begin
                    cs_n    = 1'b0;
                    mosi_n  = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    rx_n    = rx_sr;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_reader.sv
// Scoreboard bench: three masters (CLK_DIV 2, 1, 3) share stimulus;
// an arithmetic frame model predicts waveforms, done timing and rx words.
module tb_spi_master_reader;

    typedef struct {
        logic [15:0] rx;
        int          at;
    } exp_t;

    function automatic int dv(int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
    endfunction

    logic        SLK = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] tx_data;
    logic [2:0]  busy, done, sck, cs, mosi;
    logic [2:0]  miso = '0;
    logic [15:0] rx [3];

    logic        loopback;
    logic [15:0] resp;

    always #5 SLK = ~SLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        spi_master_reader #(
            .FRAME_W(16),
            .CLK_DIV(D)
        ) u_dut (
            .SLK    (SLK),
            .rst    (rst),
            .start  (start),
            .tx_data(tx_data),
            .busy   (busy[g]),
            .done   (done[g]),
            .rx_data(rx[g]),
            .SCK    (sck[g]),
            .CS     (cs[g]),
            .MOSI   (mosi[g]),
            .MISO   (miso[g])
        );
    end

    // predictor state
    int          ecnt = 0;
    bit          act [3];
    int          kacc [3];
    logic [15:0] txc [3];
    logic [15:0] expf [3];
    logic [15:0] lastrx [3];
    int          donee [3];
    exp_t        sb [3][$];

    // monitor state
    int          checks = 0;
    int          failures = 0;
    logic [2:0]  sck_prev = '0;
    logic [2:0]  cs_prev = '0;
    logic [15:0] sreg [3];
    int          tmo_req = 0;
    int          tmo_seen = 0;
    bit          fin_req = 1'b0;
    bit          fin_done = 1'b0;

    always @(posedge SLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                act[i]    = 1'b0;
                lastrx[i] = '0;
                donee[i]  = -100;
                sb[i].delete();
            end
        end else begin
            ecnt++;
            for (int i = 0; i < 3; i++) begin
                if (act[i]) begin
                    if (ecnt == kacc[i] + 33 * dv(i)) begin
                        act[i]    = 1'b0;
                        lastrx[i] = expf[i];
                        donee[i]  = ecnt;
                    end
                end else if (start) begin
                    exp_t e;
                    act[i]  = 1'b1;
                    kacc[i] = ecnt;
                    txc[i]  = tx_data;
                    e.rx    = loopback ? tx_data : resp;
                    e.at    = ecnt + 33 * dv(i);
                    expf[i] = e.rx;
                    sb[i].push_back(e);
                end
            end
        end
    end

    function automatic void chk(string nm, int inst, logic [31:0] a, logic [31:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h required=%h t=%0t", nm, inst, a, x, $time);
        end
    endfunction

    always @(negedge SLK) begin
        for (int i = 0; i < 3; i++) begin
            int d, p, idx;
            logic [4:0] wexp;
            d = dv(i);
            p = ecnt - kacc[i];
            if (act[i]) begin
                idx  = (p / (2 * d) > 15) ? 15 : p / (2 * d);
                wexp = {1'b1, 1'b1, (p >= d) && ((p / d) % 2 == 1), txc[i][15-idx], 1'b0};
            end else begin
                wexp = {4'b0000, ecnt == donee[i]};
            end
            chk("wave_busy_cs_sck_mosi_done", i, 32'({busy[i], cs[i], sck[i], mosi[i], done[i]}), 32'(wexp));
            chk("rx_hold", i, 32'(rx[i]), 32'(lastrx[i]));
            if (done[i]) begin
                if (sb[i].size() == 0) begin
                    chk("sb_unexpected_done", i, 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = sb[i].pop_front();
                    chk("sb_rx", i, 32'(rx[i]), 32'(e.rx));
                    chk("sb_done_edge", i, 32'(ecnt), 32'(e.at));
                end
            end
            // slave: reload reply at CS rise, present next bit after SCK rise
            if (cs[i] && !cs_prev[i]) sreg[i] = resp;
            if (sck[i] && !sck_prev[i]) begin
                miso[i] = loopback ? mosi[i] : sreg[i][15];
                sreg[i] = {sreg[i][14:0], 1'b0};
            end
        end
        sck_prev = sck;
        cs_prev  = cs;
        if (tmo_req != tmo_seen) begin
            chk("wait_idle_timeout", 0, 32'(1), 32'(0));
            tmo_seen++;
        end
        if (fin_req && !fin_done) begin
            for (int i = 0; i < 3; i++) chk("sb_left", i, 32'(sb[i].size()), 32'(0));
            fin_done = 1'b1;
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 400; n++) begin
            @(posedge SLK);
            #2;
            if (busy == 3'b000) return;
        end
        tmo_req++;
    endtask

    task automatic issue(input logic [15:0] w, input int extra_at);
        @(posedge SLK);
        #2;
        start   = 1'b1;
        tx_data = w;
        @(posedge SLK);
        #2;
        start   = 1'b0;
        tx_data = 16'($urandom);
        if (extra_at > 1) begin
            repeat (extra_at - 2) @(posedge SLK);
            #2;
            start = 1'b1;
            @(posedge SLK);
            #2;
            start = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        tx_data  = '0;
        loopback = 1'b0;
        resp     = '0;
        repeat (3) @(posedge SLK);
        #2;
        rst = 1'b0;

        // loopback frame with an ignored start at k+10
        wait_idle();
        loopback = 1'b1;
        issue(16'hA5C3, 10);

        // fixed slave reply
        wait_idle();
        loopback = 1'b0;
        resp     = 16'h1234;
        issue(16'hFFFF, 0);

        // reset at k+20, then a normal frame
        wait_idle();
        resp = 16'hBEEF;
        issue(16'h1357, 0);
        repeat (18) @(posedge SLK);
        #2;
        rst = 1'b1;
        @(posedge SLK);
        #2;
        rst = 1'b0;
        wait_idle();
        loopback = 1'b1;
        issue(16'h00FF, 0);

        // start held high: back-to-back frames
        wait_idle();
        loopback = 1'b0;
        resp     = 16'($urandom);
        start    = 1'b1;
        repeat (250) begin
            @(posedge SLK);
            #2;
            tx_data = 16'($urandom);
        end
        start = 1'b0;

        // random frames with stray starts
        repeat (8) begin
            wait_idle();
            loopback = 1'($urandom_range(0, 1));
            resp     = 16'($urandom);
            issue(16'($urandom), $urandom_range(0, 40));
        end

        wait_idle();
        repeat (4) @(posedge SLK);
        fin_req = 1'b1;
        repeat (3) @(posedge SLK);
        if (!fin_done) begin
            $display("FAIL final_check_not_reached");
            $fatal(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
